ws2812_chain: RTL and testbench
===============================

Name: ws2812_chain

Overview:
- Parametrised WS2812/SK6812 LED-chain driver for the user project area; successor to the single-configuration ws2812 block.
- Holds a local frame buffer of NUM_LEDS colour words, written by the management-SoC bus glue.
- On a start strobe, serialises the whole buffer MSB-first onto one GPIO (led_out) with NRZ one-wire timing, then holds the line low for the latch/reset period.
- Generalises LED count, colour-word width (24-bit GRB or 32-bit GRBW) and bit timing, and adds busy/done status.

Parameters:
- NUM_LEDS, 8: LEDs in the chain, >=1.
- BITS_PER_LED, 24: colour word width, 24 (GRB) or 32 (GRBW).
- T0H_CYC, 4: clk cycles led_out is high for a '0' bit.
- T1H_CYC, 8: clk cycles led_out is high for a '1' bit; T0H_CYC < T1H_CYC < BIT_CYC.
- BIT_CYC, 13: total clk cycles per bit.
- RESET_CYC, 500: clk cycles led_out is held low after the last bit (>=50 us at 10 MHz).
- AW, $clog2(NUM_LEDS) (min 1): address width.

Ports:
- clk  input  1  system clock
- resetb  input  1  asynchronous active-low reset
- wr_en  input  1  frame-buffer write strobe
- wr_addr  input  AW  LED index to write
- wr_data  input  BITS_PER_LED  colour word, MSB transmitted first
- start  input  1  single-cycle request to transmit the frame
- busy  output  1  frame transmission in progress
- done  output  1  one-cycle pulse at the end of the latch period
- led_out  output  1  serial data to the first LED DIN

Behaviour:
- Reset is asynchronous and active-low. While resetb=0: led_out=0, busy=0, done=0, state IDLE, all counters 0, every frame-buffer word 0. Reset asserted mid-frame aborts the frame immediately, with no done pulse.
- Writes: when wr_en=1 and state is IDLE, mem[wr_addr] <= wr_data at the clock edge.
  - Writes with wr_addr >= NUM_LEDS are ignored.
  - Writes while busy=1 are dropped; the buffer is unchanged.
- States: IDLE, LOAD, HIGH, LOW, LATCH.
- IDLE: led_out=0, busy=0. start=1 -> LOAD, busy=1 from the next cycle, led index=0.
  - If start and wr_en occur in the same cycle, the write takes effect and the frame uses the new value.
- LOAD (1 cycle): shift register <= mem[led index], bit counter = BITS_PER_LED-1 -> HIGH.
- HIGH: led_out=1 for T1H_CYC cycles if the current bit is 1, else T0H_CYC cycles -> LOW.
- LOW: led_out=0 for the remaining (BIT_CYC - high time) cycles. Then:
  - If bits remain: shift left -> HIGH.
  - Else if led index < NUM_LEDS-1: index+1 -> LOAD.
  - Else -> LATCH.
- LED boundaries: each LOAD cycle adds exactly one low cycle to the last bit of the previous LED. The first bit starts 2 cycles after the start edge.
- LATCH: led_out=0 for RESET_CYC cycles. In the final cycle, done=1 for exactly one clk; the next state is IDLE with busy=0.
- start while busy=1 is ignored; it is not queued.
- Frame length from start edge to done: NUM_LEDS*(1 + BITS_PER_LED*BIT_CYC) - 1 + RESET_CYC + 1 cycles (LOAD cycles included).
- Counters are sized to hold max(BIT_CYC, RESET_CYC). No wrap occurs within a frame.
- Outputs are registered; led_out has no glitches.

Test Plan:
- Reset/idle: assert resetb=0 mid-HIGH with led_out=1 -> led_out=0, busy=0 immediately. After release, an idle start with all-zero buffer sends 8x24 '0' bits (4 high / 9 low), then 500 low, then done.
- Single pattern: write mem[0]=24'h800001, others 0, pulse start -> first bit high 8 cycles, bits 2-23 high 4 cycles, bit 24 high 8 cycles. Every bit period is 13 cycles except the last bit of each LED (14).
- Frame timing/done: default parameters, pulse start at cycle 0 -> busy high from cycle 1. done is a single pulse at cycle 8*(1+24*13)+500. busy=0 the following cycle.
- Busy protection: during a frame, write mem[3]=24'hFFFFFF and pulse start again -> the current frame is unchanged and no second frame follows. A later frame still shows the old mem[3].
- Boundary writes: write wr_addr=7 (accepted) and, with NUM_LEDS=6, wr_addr=7 (ignored). start with wr_en in the same cycle to addr 0 -> the new value is transmitted.
- GRBW variant: BITS_PER_LED=32, NUM_LEDS=1, write 32'hA5A5A5A5 -> 32 bits match the pattern MSB-first, followed by the latch period and done.

Source files
------------

// File: rtl/ws2812_chain.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_chain
//  Description : WS2812/SK6812 LED-chain driver. Holds a frame buffer of
//                NUM_LEDS colour words. On start, it sends every word MSB-first
//                on led_out using NRZ one-wire timing. It then holds the line
//                low for the latch period and pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module ws2812_chain #(
    parameter int NUM_LEDS     = 8,
    parameter int BITS_PER_LED = 24,
    parameter int T0H_CYC      = 4,
    parameter int T1H_CYC      = 8,
    parameter int BIT_CYC      = 13,
    parameter int RESET_CYC    = 500,
    parameter int AW           = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                    clk,
    input  logic                    resetb,
    input  logic                    wr_en,
    input  logic [AW-1:0]           wr_addr,
    input  logic [BITS_PER_LED-1:0] wr_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    led_out
);

    // One counter serves the bit phases and the latch period, so it is sized
    // for the larger of the two.
    localparam int c_cnt_max = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);
    localparam int c_bit_w   = $clog2(BITS_PER_LED);
    localparam int c_msb     = BITS_PER_LED - 1;

    // Phase lengths are stored minus one because each phase runs until the counter reaches zero.
    localparam logic [c_cnt_w-1:0] c_t0h_m1  = c_cnt_w'(T0H_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_t1h_m1  = c_cnt_w'(T1H_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_t0l_m1  = c_cnt_w'(BIT_CYC - T0H_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_t1l_m1  = c_cnt_w'(BIT_CYC - T1H_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_rst_m1  = c_cnt_w'(RESET_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(BITS_PER_LED - 1);
    localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);
    localparam logic [AW-1:0]      c_last_idx = AW'(NUM_LEDS - 1);
    localparam logic [AW-1:0]      c_idx_one  = AW'(1);
    localparam logic [AW:0]        c_num_leds = (AW + 1)'(NUM_LEDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_LATCH = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [BITS_PER_LED-1:0] mem_q [NUM_LEDS];
    logic [BITS_PER_LED-1:0] mem_d [NUM_LEDS];
    logic [BITS_PER_LED-1:0] shreg_q, shreg_d;
    logic [c_bit_w-1:0]      bitcnt_q, bitcnt_d;
    logic [c_cnt_w-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic                    led_out_q, led_out_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    wr_ok;
    logic [BITS_PER_LED-1:0] ld_word;

    // Accept buffer writes only while idle and only to existing LEDs, and select the word for the current LED.
    always_comb begin
        wr_ok   = wr_en && (state_q == S_IDLE) && ({1'b0, wr_addr} < c_num_leds);
        ld_word = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_ok && (wr_addr == AW'(i))) begin
                mem_d[i] = wr_data;
            end
            if (idx_q == AW'(i)) begin
                ld_word = mem_q[i];
            end
        end
    end

    // Frame sequencer: next state, counters and registered output values.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                shreg_d  = ld_word;
                bitcnt_d = c_last_bit;
                cnt_d    = ld_word[c_msb] ? c_t1h_m1 : c_t0h_m1;
                state_d  = S_HIGH;
            end
            S_HIGH: begin
                if (cnt_q == '0) begin
                    state_d = S_LOW;
                    cnt_d   = shreg_q[c_msb] ? c_t1l_m1 : c_t0l_m1;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
            S_LOW: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_cnt_one;
                end else if (bitcnt_q != '0) begin
                    // The bit after the shift is shreg_q[c_msb-1]; use it to choose the next high time.
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q - c_bit_one;
                    cnt_d    = shreg_q[c_msb-1] ? c_t1h_m1 : c_t0h_m1;
                    state_d  = S_HIGH;
                end else if (idx_q != c_last_idx) begin
                    idx_d   = idx_q + c_idx_one;
                    state_d = S_LOAD;
                end else begin
                    cnt_d   = c_rst_m1;
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are derived from the next state and registered, so led_out cannot glitch.
        led_out_d = (state_d == S_HIGH);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_LATCH) && (cnt_d == '0);
    end

    // State, datapath and buffer registers; reset also clears the frame buffer.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            led_out_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            led_out_q <= led_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign led_out = led_out_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ws2812_chain
//  Description : Self-checking bench for ws2812_chain. It uses three
//                configurations: default 8x24, 6x24 and 1x32 GRBW. Each
//                transmitted frame is compared against a per-cycle waveform
//                built from the frame-buffer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ws2812_chain;

    localparam int T0H  = 4;
    localparam int T1H  = 8;
    localparam int BITC = 13;
    localparam int RSTC = 500;

    logic        clk = 1'b0;
    logic        resetb;
    logic [2:0]  wr_en_v;
    logic [2:0]  start_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  led_v;
    logic [2:0]  wr_addr_v [3];
    logic [31:0] wr_data_v [3];

    int          nled  [3] = '{8, 6, 1};
    int          nbits [3] = '{24, 24, 32};
    logic [31:0] mdl_mem [3][8];

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    ws2812_chain #(.NUM_LEDS(8), .BITS_PER_LED(24)) u_dut0 (
        .clk(clk), .resetb(resetb), .wr_en(wr_en_v[0]), .wr_addr(wr_addr_v[0][2:0]),
        .wr_data(wr_data_v[0][23:0]), .start(start_v[0]), .busy(busy_v[0]),
        .done(done_v[0]), .led_out(led_v[0])
    );

    ws2812_chain #(.NUM_LEDS(6), .BITS_PER_LED(24)) u_dut1 (
        .clk(clk), .resetb(resetb), .wr_en(wr_en_v[1]), .wr_addr(wr_addr_v[1][2:0]),
        .wr_data(wr_data_v[1][23:0]), .start(start_v[1]), .busy(busy_v[1]),
        .done(done_v[1]), .led_out(led_v[1])
    );

    ws2812_chain #(.NUM_LEDS(1), .BITS_PER_LED(32)) u_dut2 (
        .clk(clk), .resetb(resetb), .wr_en(wr_en_v[2]), .wr_addr(wr_addr_v[2][0:0]),
        .wr_data(wr_data_v[2]), .start(start_v[2]), .busy(busy_v[2]),
        .done(done_v[2]), .led_out(led_v[2])
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wmask(input int d);
        return (nbits[d] == 32) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
    endfunction

    // One-cycle buffer write, issued from a negedge; the model follows the addressing rule.
    task automatic wr(input int d, input int addr, input logic [31:0] data);
        wr_en_v[d]   = 1'b1;
        wr_addr_v[d] = 3'(addr);
        wr_data_v[d] = data;
        @(negedge clk);
        wr_en_v[d] = 1'b0;
        if (addr < nled[d]) mdl_mem[d][addr] = data & wmask(d);
    endtask

    // Pulse start, then compare {led_out, busy, done} on each cycle with the expected waveform.
    task automatic run_frame(input int d, input bit same_wr, input logic [31:0] same_data,
                             input bit poke);
        logic [2:0] exp_q[$];
        logic [2:0] obs;
        int         done_at;
        int         h;
        done_at = -1;
        chk_eq($sformatf("idle_busy d%0d", d), {31'd0, busy_v[d]}, 32'd0);
        start_v[d] = 1'b1;
        if (same_wr) begin
            wr_en_v[d]      = 1'b1;
            wr_addr_v[d]    = 3'd0;
            wr_data_v[d]    = same_data;
            mdl_mem[d][0]   = same_data & wmask(d);
        end
        for (int l = 0; l < nled[d]; l++) begin
            exp_q.push_back(3'b010);
            for (int b = nbits[d] - 1; b >= 0; b--) begin
                h = mdl_mem[d][l][b] ? T1H : T0H;
                repeat (h) exp_q.push_back(3'b110);
                repeat (BITC - h) exp_q.push_back(3'b010);
            end
        end
        repeat (RSTC - 1) exp_q.push_back(3'b010);
        exp_q.push_back(3'b011);
        exp_q.push_back(3'b000);
        @(negedge clk);
        start_v[d] = 1'b0;
        wr_en_v[d] = 1'b0;
        foreach (exp_q[i]) begin
            obs = {led_v[d], busy_v[d], done_v[d]};
            chk_eq($sformatf("wave d%0d cyc%0d", d, i + 1), {29'd0, obs}, {29'd0, exp_q[i]});
            if (done_v[d] && done_at < 0) done_at = i + 1;
            if (poke && i == 100) begin
                wr_en_v[d]   = 1'b1;
                wr_addr_v[d] = 3'd3;
                wr_data_v[d] = 32'hFFFF_FFFF;
                start_v[d]   = 1'b1;
            end else begin
                wr_en_v[d] = 1'b0;
                start_v[d] = 1'b0;
            end
            @(negedge clk);
        end
        chk_eq($sformatf("done_cycle d%0d", d), done_at, nled[d] * (1 + nbits[d] * BITC) + RSTC);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        resetb  = 1'b0;
        wr_en_v = '0;
        start_v = '0;
        for (int d = 0; d < 3; d++) begin
            wr_addr_v[d] = '0;
            wr_data_v[d] = '0;
            for (int a = 0; a < 8; a++) mdl_mem[d][a] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++)
            chk_eq($sformatf("reset_out d%0d", d), {29'd0, led_v[d], busy_v[d], done_v[d]}, 32'd0);
        resetb = 1'b1;
        @(negedge clk);

        // Abort a frame during a HIGH phase. Reset takes effect at once and also clears the buffer.
        wr(0, 0, 32'h00FF_FFFF);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        chk_eq("pre_rst_led", {31'd0, led_v[0]}, 32'd1);
        chk_eq("pre_rst_busy", {31'd0, busy_v[0]}, 32'd1);
        #2 resetb = 1'b0;
        #1;
        chk_eq("async_rst_out", {29'd0, led_v[0], busy_v[0], done_v[0]}, 32'd0);
        @(negedge clk);
        resetb = 1'b1;
        for (int d = 0; d < 3; d++)
            for (int a = 0; a < 8; a++) mdl_mem[d][a] = '0;
        @(negedge clk);
        run_frame(0, 1'b0, 32'd0, 1'b0);

        // Single pattern: long first and last bits of LED 0.
        wr(0, 0, 32'h0080_0001);
        run_frame(0, 1'b0, 32'd0, 1'b0);

        // Random buffer. A write and a start during the frame must be ignored.
        for (int a = 0; a < 8; a++) wr(0, a, $urandom);
        wr(0, 7, $urandom);
        run_frame(0, 1'b0, 32'd0, 1'b1);
        repeat (20) begin
            chk_eq("no_refire", {30'd0, busy_v[0], done_v[0]}, 32'd0);
            @(negedge clk);
        end
        run_frame(0, 1'b0, 32'd0, 1'b0);

        // Six-LED chain: out-of-range writes, then a start with a same-cycle write.
        for (int k = 0; k < 10; k++) wr(1, $urandom_range(0, 7), $urandom);
        wr(1, 6, $urandom);
        wr(1, 7, $urandom);
        run_frame(1, 1'b1, $urandom, 1'b0);

        // GRBW single LED.
        wr(2, 0, 32'hA5A5_A5A5);
        run_frame(2, 1'b0, 32'd0, 1'b0);
        run_frame(2, 1'b1, $urandom, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
`default_nettype wire
